// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The optional subtract path is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_ZERO = SEG_0;
    localparam logic [6:0] SEG_ONE  = SEG_1;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_seg7
    import serial_adder_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_ZERO;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_ZERO;
        endcase
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice walked LSB-first over WIDTH bits.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port (a - b as a + ~b + 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [6:0]       seg_sum_o,
    output logic [6:0]       seg_cout_o,
    output logic [7:0]       leddim_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rsum_q, rsum_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             sub_sel;
    logic             slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] rsum_shift;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub_i;
`else
    assign sub_sel = 1'b0;
`endif

    assign slice_s    = ra_q[0] ^ rb_q[0] ^ c_q;
    assign slice_c    = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign rsum_shift = {slice_s, rsum_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rsum_d  = rsum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ra_d    = a_i;
                    // Subtraction folds the +1 of two's complement into the carry-in.
                    rb_d    = sub_sel ? ~b_i : b_i;
                    c_d     = sub_sel;
                    rsum_d  = '0;
                    cnt_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                ra_d   = ra_q >> 1;
                rb_d   = rb_q >> 1;
                c_d    = slice_c;
                rsum_d = rsum_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    sum_d   = rsum_shift;
                    cout_d  = slice_c;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            rsum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rsum_q  <= rsum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign sum_o    = sum_q;
    assign cout_o   = cout_q;
    assign leddim_o = 8'b0;

    // Narrow results zero-extend; wide results show only the low nibble.
    hex_to_seg7 u_seg_sum (
        .hex_i (4'(sum_q)),
        .seg_o (seg_sum_o)
    );

    hex_to_seg7 u_seg_cout (
        .hex_i ({3'b000, cout_q}),
        .seg_o (seg_cout_o)
    );

endmodule
